// File: rtl/pivot_col_select.sv
// Entering-column selector for the simplex pivot: scans the objective row and picks
// the most negative reduced cost, or reports termination when none is negative.
module pivot_col_select #(
    parameter int IDX_WIDTH    = 10,
    parameter bit EXCLUDE_LAST = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 halt,
    input  logic [31:0]          s_axis_tdata,
    input  logic [3:0]           s_axis_tstrb,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 done,
    output logic                 terminate,
    output logic [IDX_WIDTH-1:0] pivot_col_idx,
    output logic [31:0]          pivot_col_val,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [31:0]          best_val_q, best_val_d;
    logic                 best_valid_q, best_valid_d;
    logic                 wrapped_q, wrapped_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;
    logic                 terminate_q, terminate_d;
    logic [IDX_WIDTH-1:0] pivot_col_idx_q, pivot_col_idx_d;
    logic [31:0]          pivot_col_val_q, pivot_col_val_d;

    logic is_candidate;
    logic eligible;
    logic better;
    logic unused_tstrb;

    assign unused_tstrb = ^s_axis_tstrb;

    always_comb begin
        // Negative, non-zero and not NaN; -inf qualifies
        is_candidate = s_axis_tdata[31] && (s_axis_tdata[30:0] != 31'd0) &&
                       !((s_axis_tdata[30:23] == 8'hFF) && (s_axis_tdata[22:0] != 23'd0));
        eligible     = is_candidate && !wrapped_q && !(EXCLUDE_LAST && s_axis_tlast);
        // For negative floats a larger magnitude field is a more negative value
        better       = !best_valid_q || (s_axis_tdata[30:0] > best_val_q[30:0]);

        state_d         = state_q;
        cnt_d           = cnt_q;
        best_idx_d      = best_idx_q;
        best_val_d      = best_val_q;
        best_valid_d    = best_valid_q;
        wrapped_d       = wrapped_q;
        overflow_d      = overflow_q;
        done_d          = 1'b0;
        terminate_d     = terminate_q;
        pivot_col_idx_d = pivot_col_idx_q;
        pivot_col_val_d = pivot_col_val_q;

        case (state_q)
            IDLE: begin
                if (start && !halt) begin
                    state_d      = SCAN;
                    cnt_d        = '0;
                    best_valid_d = 1'b0;
                    wrapped_d    = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            SCAN: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (s_axis_tvalid) begin
                    if (eligible && better) begin
                        best_idx_d   = cnt_q;
                        best_val_d   = s_axis_tdata;
                        best_valid_d = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q == '1) && !s_axis_tlast) begin
                        overflow_d = 1'b1;
                        wrapped_d  = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!halt) begin
                    done_d = 1'b1;
                    if (best_valid_q) begin
                        terminate_d     = 1'b0;
                        pivot_col_idx_d = best_idx_q;
                        pivot_col_val_d = best_val_q;
                    end else begin
                        terminate_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            best_idx_q      <= '0;
            best_val_q      <= '0;
            best_valid_q    <= 1'b0;
            wrapped_q       <= 1'b0;
            overflow_q      <= 1'b0;
            done_q          <= 1'b0;
            terminate_q     <= 1'b0;
            pivot_col_idx_q <= '0;
            pivot_col_val_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            best_idx_q      <= best_idx_d;
            best_val_q      <= best_val_d;
            best_valid_q    <= best_valid_d;
            wrapped_q       <= wrapped_d;
            overflow_q      <= overflow_d;
            done_q          <= done_d;
            terminate_q     <= terminate_d;
            pivot_col_idx_q <= pivot_col_idx_d;
            pivot_col_val_q <= pivot_col_val_d;
        end
    end

    assign s_axis_tready = (state_q == SCAN);
    assign done          = done_q;
    assign terminate     = terminate_q;
    assign pivot_col_idx = pivot_col_idx_q;
    assign pivot_col_val = pivot_col_val_q;
    assign overflow      = overflow_q;

endmodule
